// File: rtl/fb_write_scheduler.sv
// Round-robin arbiter and rectangle rasteriser feeding the frame-buffer write port.
// Emits one clipped pixel per cycle and freezes while the buffer-swap window is open.
module fb_write_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int COOR_WIDTH = 12,
  parameter int FRAME_W    = 1280,
  parameter int FRAME_H    = 300
) (
  input  logic                          clk_33m,
  input  logic                          rst_n_33m,
  input  logic                          rst_screen_33m,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*COOR_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*COOR_WIDTH-1:0] req_y,
  input  logic [NUM_REQ*COOR_WIDTH-1:0] req_w,
  input  logic [NUM_REQ*COOR_WIDTH-1:0] req_h,
  input  logic [NUM_REQ*2-1:0]          req_palette,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          busy,
  output logic [COOR_WIDTH-1:0]         write_x,
  output logic [COOR_WIDTH-1:0]         write_y,
  output logic [1:0]                    write_palette
);

  localparam int CW = COOR_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, DRAW} state_t;
  state_t state, state_next;

  logic [PW-1:0] ptr, ptr_next, grant, owner, cand;
  logic          found, accept, stall, load;
  int unsigned   idx;

  logic [CW-1:0] base_x, base_y, base_w, base_h, dx, dy;
  logic [1:0]    base_pal;
  logic [CW-1:0] out_x, out_y;
  logic [1:0]    out_pal;
  logic          out_last;

  logic [CW-1:0] src_x, src_y, src_w, src_h, nx, ny;
  logic [1:0]    src_pal, n_pal;
  logic [CW:0]   px, py;
  logic          degenerate, clipped, n_last;

  assign stall = rst_screen_33m;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = idx[PW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept   = (state == IDLE) && !stall && found;
  assign ptr_next = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Registers hold the pixel on the outputs now; this computes the one to present next.
  always_comb begin
    src_x   = base_x;
    src_y   = base_y;
    src_w   = base_w;
    src_h   = base_h;
    src_pal = base_pal;
    nx      = '0;
    ny      = '0;
    if (state == IDLE) begin
      src_x   = req_x[grant*CW +: CW];
      src_y   = req_y[grant*CW +: CW];
      src_w   = req_w[grant*CW +: CW];
      src_h   = req_h[grant*CW +: CW];
      src_pal = req_palette[grant*2 +: 2];
    end else if (dx == base_w - 1'b1) begin
      ny = dy + 1'b1;
    end else begin
      nx = dx + 1'b1;
      ny = dy;
    end
  end

  assign px         = {1'b0, src_x} + {1'b0, nx};
  assign py         = {1'b0, src_y} + {1'b0, ny};
  assign degenerate = (src_w == '0) || (src_h == '0);
  assign clipped    = (px >= (CW+1)'(FRAME_W)) || (py >= (CW+1)'(FRAME_H));
  assign n_last     = degenerate || ((nx == src_w - 1'b1) && (ny == src_h - 1'b1));
  assign n_pal      = (degenerate || clipped) ? 2'b00 : src_pal;
  assign load       = accept || ((state == DRAW) && !stall && !out_last);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = DRAW;
      DRAW: if (!stall && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_33m) begin
    if (!rst_n_33m) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge clk_33m) begin
    if (!rst_n_33m) begin
      ptr      <= '0;
      owner    <= '0;
      base_x   <= '0;
      base_y   <= '0;
      base_w   <= '0;
      base_h   <= '0;
      base_pal <= '0;
      dx       <= '0;
      dy       <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_pal  <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept) begin
        base_x   <= src_x;
        base_y   <= src_y;
        base_w   <= src_w;
        base_h   <= src_h;
        base_pal <= src_pal;
        owner    <= grant;
        ptr      <= ptr_next;
      end
      if (load) begin
        dx       <= nx;
        dy       <= ny;
        out_pal  <= n_pal;
        out_last <= n_last;
        if (!degenerate && !clipped) begin
          out_x <= px[CW-1:0];
          out_y <= py[CW-1:0];
        end
      end else if ((state == DRAW) && !stall) begin
        out_pal  <= '0;
        out_last <= 1'b0;
      end
    end
  end

  // The swap window gates the held pixel in the same cycle; the raster only advances when it was emitted.
  always_comb begin
    req_done = '0;
    if ((state == DRAW) && !stall && out_last) req_done[owner] = 1'b1;
  end

  assign busy          = (state == DRAW);
  assign write_x       = out_x;
  assign write_y       = out_y;
  assign write_palette = ((state == DRAW) && !stall) ? out_pal : 2'b00;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: directed scenarios plus randomized traffic checked
// against a pixel-list model of each rectangle and a round-robin grant model.
module tb_fb_write_scheduler;

  localparam int NR = 4;
  localparam int CW = 12;

  logic              clk_33m = 1'b0;
  logic              rst_n_33m, rst_screen_33m;
  logic [NR-1:0]     req_valid, req_ready, req_done;
  logic [NR*CW-1:0]  req_x, req_y, req_w, req_h;
  logic [NR*2-1:0]   req_palette;
  logic              busy;
  logic [CW-1:0]     write_x, write_y;
  logic [1:0]        write_palette;

  always #5 clk_33m = ~clk_33m;

  fb_write_scheduler #(.NUM_REQ(NR), .COOR_WIDTH(CW), .FRAME_W(1280), .FRAME_H(300)) dut (
    .clk_33m(clk_33m), .rst_n_33m(rst_n_33m), .rst_screen_33m(rst_screen_33m),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_palette(req_palette), .req_done(req_done), .busy(busy),
    .write_x(write_x), .write_y(write_y), .write_palette(write_palette)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int x; int y; int pal; } pix_t;
  pix_t exp_q[$];
  int   m_ptr = 0;
  int   cx[NR], cy[NR], cw[NR], ch[NR], cp[NR];

  // Expected write stream of one rectangle, row-major, clipped to the 1280x300 frame.
  function automatic void model_rect(input int x, input int y, input int w, input int h, input int pal);
    pix_t p;
    exp_q.delete();
    if (w == 0 || h == 0) begin
      p = '{0, 0, 0};
      exp_q.push_back(p);
      return;
    end
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        p.x = x + c;
        p.y = y + r;
        p.pal = (p.x >= 1280 || p.y >= 300) ? 0 : pal;
        exp_q.push_back(p);
      end
  endfunction

  function automatic int model_grant(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++)
      if (v[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    return -1;
  endfunction

  task automatic set_cmd(input int i, input int x, input int y, input int w, input int h, input int pal);
    cx[i] = x; cy[i] = y; cw[i] = w; ch[i] = h; cp[i] = pal;
    req_x[i*CW +: CW] = CW'(x);
    req_y[i*CW +: CW] = CW'(y);
    req_w[i*CW +: CW] = CW'(w);
    req_h[i*CW +: CW] = CW'(h);
    req_palette[i*2 +: 2] = 2'(pal);
    req_valid[i] = 1'b1;
  endtask

  task automatic rand_cmd(input int i);
    int x, y;
    x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(1262, 1290);
    y = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(282, 310);
    set_cmd(i, x, y, $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n_33m = 1'b0; rst_screen_33m = 1'b0; req_valid = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_palette = '0;
    repeat (2) @(posedge clk_33m);
    #1 rst_n_33m = 1'b1;
    m_ptr = 0;
    @(negedge clk_33m);
    vectors++; if (write_x !== '0) begin miscompares++; $display("FAIL reset_x got %0d exp 0", write_x); end
    vectors++; if (write_y !== '0) begin miscompares++; $display("FAIL reset_y got %0d exp 0", write_y); end
    vectors++; if (write_palette !== 2'd0) begin miscompares++; $display("FAIL reset_pal got %0d exp 0", write_palette); end
    vectors++; if (req_done !== '0) begin miscompares++; $display("FAIL reset_done got %b exp 0", req_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", req_ready); end
  endtask

  task automatic test_round_robin();
    int g;
    @(posedge clk_33m); #1;
    for (int i = 0; i < NR; i++) set_cmd(i, 100 + i*10, 20, 1, 1, (i % 3) + 1);
    for (int n = 0; n < 2*NR; n++) begin
      @(negedge clk_33m);
      g = n % NR;
      vectors++; if (req_ready !== NR'(1 << g)) begin miscompares++; $display("FAIL rr_grant n=%0d got %b exp %b", n, req_ready, NR'(1 << g)); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_bubble n=%0d busy got %b exp 0", n, busy); end
      m_ptr = (g + 1) % NR;
      @(posedge clk_33m); #1;
      if (n >= NR) req_valid[g] = 1'b0;
      @(negedge clk_33m);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_busy n=%0d got %b exp 1", n, busy); end
      vectors++; if ($countones(req_ready) > 1 || req_ready !== '0) begin miscompares++; $display("FAIL rr_ready_draw n=%0d got %b exp 0", n, req_ready); end
      vectors++; if (write_x !== CW'(100 + g*10) || write_palette !== 2'((g % 3) + 1)) begin
        miscompares++; $display("FAIL rr_pixel n=%0d got x=%0d pal=%0d exp x=%0d pal=%0d", n, write_x, write_palette, 100 + g*10, (g % 3) + 1); end
      vectors++; if (req_done !== NR'(1 << g)) begin miscompares++; $display("FAIL rr_done n=%0d got %b exp %b", n, req_done, NR'(1 << g)); end
    end
  endtask

  task automatic test_single();
    pix_t e;
    int g;
    @(posedge clk_33m); #1;
    set_cmd(0, 10, 5, 3, 2, 2);
    model_rect(10, 5, 3, 2, 2);
    @(negedge clk_33m);
    g = model_grant(req_valid);
    vectors++; if (req_ready !== NR'(1 << g)) begin miscompares++; $display("FAIL single_ready got %b exp %b", req_ready, NR'(1 << g)); end
    m_ptr = (g + 1) % NR;
    @(posedge clk_33m); #1 req_valid[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_33m);
      e = exp_q.pop_front();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy k=%0d got %b exp 1", k, busy); end
      vectors++; if (write_x !== CW'(e.x) || write_y !== CW'(e.y) || write_palette !== 2'(e.pal)) begin
        miscompares++; $display("FAIL single_pixel k=%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", k, write_x, write_y, write_palette, e.x, e.y, e.pal); end
      vectors++; if (req_done !== ((k == 5) ? NR'(1) : NR'(0))) begin miscompares++; $display("FAIL single_done k=%0d got %b", k, req_done); end
    end
    @(negedge clk_33m);
    vectors++; if (busy !== 1'b0 || write_palette !== 2'd0) begin miscompares++; $display("FAIL single_end got busy=%b pal=%0d exp 0,0", busy, write_palette); end
  endtask

  task automatic test_clip();
    pix_t e;
    int g;
    @(posedge clk_33m); #1;
    set_cmd(1, 1278, 299, 4, 2, 2);
    model_rect(1278, 299, 4, 2, 2);
    @(negedge clk_33m);
    g = model_grant(req_valid);
    vectors++; if (req_ready !== NR'(1 << g)) begin miscompares++; $display("FAIL clip_ready got %b exp %b", req_ready, NR'(1 << g)); end
    m_ptr = (g + 1) % NR;
    @(posedge clk_33m); #1 req_valid[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_33m);
      e = exp_q.pop_front();
      vectors++; if (write_palette !== 2'(e.pal)) begin miscompares++; $display("FAIL clip_pal k=%0d got %0d exp %0d", k, write_palette, e.pal); end
      if (e.pal != 0) begin
        vectors++; if (write_x !== CW'(e.x) || write_y !== CW'(e.y)) begin miscompares++; $display("FAIL clip_xy k=%0d got (%0d,%0d) exp (%0d,%0d)", k, write_x, write_y, e.x, e.y); end
      end
      vectors++; if (req_done !== ((k == 7) ? NR'(2) : NR'(0))) begin miscompares++; $display("FAIL clip_done k=%0d got %b", k, req_done); end
    end
    @(negedge clk_33m);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clip_end busy got %b exp 0", busy); end
  endtask

  task automatic test_stall();
    pix_t e;
    int g;
    @(posedge clk_33m); #1;
    set_cmd(2, 50, 60, 4, 1, 3);
    model_rect(50, 60, 4, 1, 3);
    @(negedge clk_33m);
    g = model_grant(req_valid);
    vectors++; if (req_ready !== NR'(1 << g)) begin miscompares++; $display("FAIL stall_ready got %b exp %b", req_ready, NR'(1 << g)); end
    m_ptr = (g + 1) % NR;
    @(posedge clk_33m); #1 req_valid[2] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      rst_screen_33m = (k >= 2 && k <= 6);
      @(negedge clk_33m);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy k=%0d got %b exp 1", k, busy); end
      if (rst_screen_33m) begin
        vectors++; if (write_palette !== 2'd0 || req_done !== '0) begin miscompares++; $display("FAIL stall_hold k=%0d got pal=%0d done=%b exp 0", k, write_palette, req_done); end
      end else begin
        e = exp_q.pop_front();
        vectors++; if (write_x !== CW'(e.x) || write_y !== CW'(e.y) || write_palette !== 2'(e.pal)) begin
          miscompares++; $display("FAIL stall_pixel k=%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", k, write_x, write_y, write_palette, e.x, e.y, e.pal); end
        vectors++; if (req_done !== ((exp_q.size() == 0) ? NR'(4) : NR'(0))) begin miscompares++; $display("FAIL stall_done k=%0d got %b", k, req_done); end
      end
      @(posedge clk_33m); #1;
    end
    rst_screen_33m = 1'b1;
    set_cmd(3, 7, 8, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_33m);
      vectors++; if (req_ready !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL stall_idle k=%0d got ready=%b busy=%b exp 0,0", k, req_ready, busy); end
      @(posedge clk_33m); #1;
    end
    rst_screen_33m = 1'b0;
    @(negedge clk_33m);
    g = model_grant(req_valid);
    vectors++; if (req_ready !== NR'(1 << g)) begin miscompares++; $display("FAIL stall_resume_ready got %b exp %b", req_ready, NR'(1 << g)); end
    m_ptr = (g + 1) % NR;
    @(posedge clk_33m); #1 req_valid[3] = 1'b0;
    @(negedge clk_33m);
    vectors++; if (req_done !== NR'(8) || write_palette !== 2'd1) begin miscompares++; $display("FAIL stall_resume_done got done=%b pal=%0d exp 1000,1", req_done, write_palette); end
  endtask

  task automatic test_degenerate();
    int g;
    @(posedge clk_33m); #1;
    set_cmd(0, 30, 30, 0, 5, 1);
    @(negedge clk_33m);
    g = model_grant(req_valid);
    vectors++; if (req_ready !== NR'(1 << g)) begin miscompares++; $display("FAIL degen_ready got %b exp %b", req_ready, NR'(1 << g)); end
    m_ptr = (g + 1) % NR;
    @(posedge clk_33m); #1 req_valid[0] = 1'b0;
    @(negedge clk_33m);
    vectors++; if (busy !== 1'b1 || write_palette !== 2'd0 || req_done !== NR'(1)) begin
      miscompares++; $display("FAIL degen_draw got busy=%b pal=%0d done=%b exp 1,0,0001", busy, write_palette, req_done); end
    @(negedge clk_33m);
    vectors++; if (busy !== 1'b0 || req_done !== '0) begin miscompares++; $display("FAIL degen_end got busy=%b done=%b exp 0,0", busy, req_done); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk_33m); #1;
    set_cmd(1, 200, 100, 5, 5, 1);
    @(posedge clk_33m); #1 req_valid[1] = 1'b0;
    repeat (3) @(posedge clk_33m);
    #1 rst_n_33m = 1'b0;
    @(posedge clk_33m); #1 rst_n_33m = 1'b1;
    m_ptr = 0;
    exp_q.delete();
    @(negedge clk_33m);
    vectors++; if (write_x !== '0 || write_y !== '0 || write_palette !== 2'd0) begin
      miscompares++; $display("FAIL rstmid_out got (%0d,%0d,%0d) exp (0,0,0)", write_x, write_y, write_palette); end
    vectors++; if (busy !== 1'b0 || req_done !== '0) begin miscompares++; $display("FAIL rstmid_state got busy=%b done=%b exp 0,0", busy, req_done); end
    @(posedge clk_33m); #1;
  endtask

  // Random traffic; the first arbitration after test_reset_mid also confirms the pointer restarted at 0.
  task automatic test_random();
    pix_t e;
    int g, owner, acc, rects;
    bit in_draw;
    logic [NR-1:0] expd;
    owner = 0; acc = -1; rects = 0; in_draw = 0;
    for (int i = 0; i < NR; i++) rand_cmd(i);
    for (int cyc = 0; cyc < 8000 && rects < 60; cyc++) begin
      if (acc >= 0) begin
        if ($urandom_range(0, 3) != 0) rand_cmd(acc); else req_valid[acc] = 1'b0;
        acc = -1;
      end
      if (req_valid == '0) rand_cmd($urandom_range(0, NR-1));
      rst_screen_33m = ($urandom_range(0, 9) == 0);
      @(negedge clk_33m);
      vectors++; if (busy !== in_draw) begin miscompares++; $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, busy, in_draw); end
      if (in_draw) begin
        vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL rnd_ready_draw cyc=%0d got %b exp 0", cyc, req_ready); end
        if (rst_screen_33m) begin
          vectors++; if (write_palette !== 2'd0 || req_done !== '0) begin miscompares++; $display("FAIL rnd_stall cyc=%0d got pal=%0d done=%b exp 0,0", cyc, write_palette, req_done); end
        end else begin
          e = exp_q.pop_front();
          vectors++; if (write_palette !== 2'(e.pal)) begin miscompares++; $display("FAIL rnd_pal cyc=%0d got %0d exp %0d", cyc, write_palette, e.pal); end
          if (e.pal != 0) begin
            vectors++; if (write_x !== CW'(e.x) || write_y !== CW'(e.y)) begin miscompares++; $display("FAIL rnd_xy cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc, write_x, write_y, e.x, e.y); end
          end
          expd = (exp_q.size() == 0) ? NR'(1 << owner) : NR'(0);
          vectors++; if (req_done !== expd) begin miscompares++; $display("FAIL rnd_done cyc=%0d got %b exp %b", cyc, req_done, expd); end
          if (exp_q.size() == 0) begin in_draw = 0; rects++; end
        end
      end else begin
        vectors++; if (write_palette !== 2'd0 || req_done !== '0) begin miscompares++; $display("FAIL rnd_idle cyc=%0d got pal=%0d done=%b exp 0,0", cyc, write_palette, req_done); end
        g = rst_screen_33m ? -1 : model_grant(req_valid);
        expd = (g >= 0) ? NR'(1 << g) : NR'(0);
        vectors++; if (req_ready !== expd) begin miscompares++; $display("FAIL rnd_grant cyc=%0d got %b exp %b", cyc, req_ready, expd); end
        if (g >= 0) begin
          model_rect(cx[g], cy[g], cw[g], ch[g], cp[g]);
          owner = g; m_ptr = (g + 1) % NR; in_draw = 1; acc = g;
        end
      end
      @(posedge clk_33m); #1;
    end
    vectors++; if (rects < 60) begin miscompares++; $display("FAIL rnd_timeout got %0d rects exp 60", rects); end
    rst_screen_33m = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_clip();
    test_stall();
    test_degenerate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sits in the clk_33m domain in front of the frame-buffer write port (write_x / write_y / write_palette) of the VGA block.
- Arbitrates rectangle-fill commands from NUM_REQ drawing requesters, round-robin.
- Expands each granted rectangle into one pixel write per cycle, clips it to the frame area, and stalls while rst_screen_33m (buffer swap window) is high.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- COOR_WIDTH, 12, coordinate width; must match the VGA block.
- FRAME_W, 1280, frame width in pixels (write_x range).
- FRAME_H, 300, frame height in pixels (write_y range).

Ports:
- clk_33m  in  1  sole clock.
- rst_n_33m  in  1  reset, synchronous, active-low.
- rst_screen_33m  in  1  buffer-swap window from the VGA block; while high, no writes.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_x  in  NUM_REQ*COOR_WIDTH  rectangle left edge, packed; requester i at [i*W +: W].
- req_y  in  NUM_REQ*COOR_WIDTH  rectangle top edge, packed.
- req_w  in  NUM_REQ*COOR_WIDTH  rectangle width in pixels.
- req_h  in  NUM_REQ*COOR_WIDTH  rectangle height in pixels.
- req_palette  in  NUM_REQ*2  fill palette index.
- req_done  out  NUM_REQ  one-cycle pulse to the owner when its rectangle completes.
- busy  out  1  high while in DRAW.
- write_x  out  COOR_WIDTH  pixel x to the VGA block.
- write_y  out  COOR_WIDTH  pixel y to the VGA block.
- write_palette  out  2  pixel palette; 0 means no write.

Interface decision: one clock; reset is synchronous and active-low. Clock is clk_33m, reset is rst_n_33m.

Behaviour:
- Reset (rst_n_33m low at a clk edge):
  - Outputs: write_x=0, write_y=0, write_palette=0, req_done=0, busy=0.
  - State: FSM in IDLE, round-robin pointer=0.
  - An in-flight rectangle is abandoned and produces no req_done.
- FSM states: IDLE, DRAW.
- Arbitration (IDLE, rst_screen_33m low):
  - Grant goes to the first requester with req_valid set, searching from the pointer upward with modulo NUM_REQ wrap.
  - req_ready[g] is combinational: high only for g, in IDLE, with rst_screen_33m low.
  - Handshake is valid&ready. Requesters hold valid and data stable until accepted; valid may not be withdrawn.
  - On accept: latch x, y, w, h, palette and owner g; set pointer=(g+1) mod NUM_REQ; go to DRAW.
- Degenerate command (w==0 or h==0):
  - Still accepted; one DRAW cycle with write_palette=0.
  - req_done[g] pulses in that cycle; return to IDLE.
- DRAW, raster generation:
  - Offsets dx, dy start at 0; row-major order, dx increments first.
  - Advance rule: at dx==w-1, dx←0 and dy++.
  - Outputs are registered. The first pixel (x, y) appears on write_* the cycle after accept, so latency is 1.
  - Throughput is 1 pixel per cycle. One IDLE bubble separates consecutive rectangles.
- Arithmetic and clipping:
  - Pixel coordinates px=x+dx and py=y+dy are computed at COOR_WIDTH+1 bits, so there is no wrap.
  - Clipped pixel (px>=FRAME_W or py>=FRAME_H): write_palette=0 for that cycle; it still consumes the cycle.
  - Unclipped pixel: write_x=px[COOR_WIDTH-1:0], write_y=py[COOR_WIDTH-1:0], write_palette=latched palette.
  - A latched palette of 0 yields no writes but runs to completion normally.
- Last pixel (dx==w-1 and dy==h-1): req_done[owner] pulses in the same cycle the last pixel is output; FSM is IDLE the next cycle.
- rst_screen_33m high during DRAW:
  - dx, dy hold; write_palette=0; req_done is suppressed.
  - Raster resumes from the held pixel on the first cycle rst_screen_33m is low, with no pixel lost or duplicated.
- rst_screen_33m high in IDLE: all req_ready low; no accept.
- busy=1 exactly while the state is DRAW, including stall cycles.
- In IDLE, write_palette=0 and write_x/write_y hold their last values.

Test Plan:
- Single rectangle: req 0 sends x=10,y=5,w=3,h=2,pal=2. Required: writes (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) on 6 consecutive cycles starting one cycle after accept; req_done[0] on the 6th; busy high exactly 6 cycles.
- Round-robin: all 4 requesters valid continuously with 1x1 rectangles. Required: grants 0,1,2,3,0 in that order; one IDLE bubble between rectangles; never two ready bits high.
- Clipping: x=1278,w=4,y=299,h=2. Required: palette 2 at (1278,299) and (1279,299); the other 6 cycles carry write_palette=0; req_done after 8 draw cycles.
- Stall: rst_screen_33m high for 5 cycles during the 3rd pixel of a 4x1 rectangle. Required: palette 0 and held counters for those 5 cycles, then pixels 3 and 4 once each; no accepts while it is high in IDLE.
- Degenerate and reset:
  - w=0: accepted; one busy cycle; req_done pulses; no writes.
  - rst_n_33m low mid-rectangle: next cycle all outputs are 0, the FSM is IDLE, the pointer is 0, and no req_done pulses.
